// File: rtl/uart_link.sv
// 8N1 UART transmitter and receiver sharing one oversample tick, plus a little-endian two-byte word assembler.
// TX starts on the first bit tick after a request; RX flags a byte at mid stop bit, and the word follows 2 clocks later.
module uart_link #(
    parameter int CLKS_PER_SAMPLE = 28,
    parameter int OVERSAMPLE      = 16,
    parameter int WORD_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_n,
    input  logic [7:0]            tx_data,
    output logic                  tx,
    output logic                  ready_to_send,
    input  logic                  rx,
    output logic [7:0]            rx_byte,
    output logic                  byte_ready,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_ready
);
    localparam int CW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam int SW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_SAMPLE - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [CW-1:0]   r_clk_cnt;
    logic [SW-1:0]   r_samp_cnt;
    logic            w_sample_tick;
    logic            w_bit_tick;

    logic [2:0]      r_start_sync;
    logic            w_start_fall;
    tx_state_t       r_tx_state;
    tx_state_t       w_tx_next;
    logic            r_pending;
    logic [7:0]      r_tx_shift;
    logic [2:0]      r_tx_bits;

    logic [1:0]      r_rx_sync;
    rx_state_t       r_rx_state;
    rx_state_t       w_rx_next;
    logic            w_rx_mid;
    logic [SW-1:0]   r_rx_cnt;
    logic [2:0]      r_rx_bits;
    logic [7:0]      r_rx_shift;
    logic [7:0]      r_rx_byte;
    logic            r_byte_ready;

    logic            r_byte_ready_d;
    logic            w_byte_edge;
    logic            r_word_idx;
    logic [7:0]      r_lo_byte;
    logic [WORD_WIDTH-1:0] r_word;
    logic            r_word_stored;
    logic            r_word_ready;

    assign w_sample_tick = (r_clk_cnt == CLK_LAST);
    assign w_bit_tick    = w_sample_tick && (r_samp_cnt == SAMP_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_cnt  <= '0;
            r_samp_cnt <= '0;
        end else if (w_sample_tick) begin
            r_clk_cnt  <= '0;
            r_samp_cnt <= (r_samp_cnt == SAMP_LAST) ? '0 : r_samp_cnt + 1'b1;
        end else begin
            r_clk_cnt  <= r_clk_cnt + 1'b1;
        end
    end

    assign w_start_fall  = r_start_sync[2] && !r_start_sync[1];
    assign ready_to_send = (r_tx_state == TX_IDLE) && !r_pending;

    always_comb begin
        w_tx_next = r_tx_state;
        tx        = 1'b1;
        case (r_tx_state)
            TX_IDLE:  if (r_pending && w_bit_tick) w_tx_next = TX_START;
            TX_START: begin
                tx = 1'b0;
                if (w_bit_tick) w_tx_next = TX_DATA;
            end
            TX_DATA: begin
                tx = r_tx_shift[0];
                if (w_bit_tick && r_tx_bits == 3'd7) w_tx_next = TX_STOP;
            end
            TX_STOP:  if (w_bit_tick) w_tx_next = TX_IDLE;
            default:  w_tx_next = TX_IDLE;
        endcase
    end

    // Requests are only taken in IDLE with nothing pending, so nothing ever queues behind a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_start_sync <= '1;
            r_tx_state   <= TX_IDLE;
            r_pending    <= 1'b0;
            r_tx_shift   <= '0;
            r_tx_bits    <= '0;
        end else begin
            r_start_sync <= {r_start_sync[1:0], start_n};
            r_tx_state   <= w_tx_next;
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_next == TX_START) begin
                        r_pending <= 1'b0;
                    end else if (!r_pending && w_start_fall) begin
                        r_pending  <= 1'b1;
                        r_tx_shift <= tx_data;
                    end
                end
                TX_START: r_tx_bits <= '0;
                TX_DATA: begin
                    if (w_bit_tick) begin
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_bits  <= r_tx_bits + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_mid  = (r_rx_state == RX_START) ? (r_rx_cnt == HALF_LAST) : (r_rx_cnt == SAMP_LAST);
        case (r_rx_state)
            RX_IDLE:  if (w_sample_tick && !r_rx_sync[1]) w_rx_next = RX_START;
            RX_START: if (w_sample_tick && w_rx_mid) w_rx_next = r_rx_sync[1] ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_sample_tick && w_rx_mid && r_rx_bits == 3'd7) w_rx_next = RX_STOP;
            RX_STOP:  if (w_sample_tick && w_rx_mid) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    // The tick counter restarts at each mid-bit sample so later samples stay centred in their bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_sync    <= '1;
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bits    <= '0;
            r_rx_shift   <= '0;
            r_rx_byte    <= '0;
            r_byte_ready <= 1'b0;
        end else begin
            r_rx_sync  <= {r_rx_sync[0], rx};
            r_rx_state <= w_rx_next;
            if (w_sample_tick) begin
                r_rx_cnt <= (r_rx_state == RX_IDLE || w_rx_mid) ? '0 : r_rx_cnt + 1'b1;
                case (r_rx_state)
                    RX_START: begin
                        if (w_rx_mid && !r_rx_sync[1]) begin
                            r_rx_bits    <= '0;
                            r_byte_ready <= 1'b0;
                        end
                    end
                    RX_DATA: begin
                        if (w_rx_mid) begin
                            r_rx_shift <= {r_rx_sync[1], r_rx_shift[7:1]};
                            r_rx_bits  <= r_rx_bits + 1'b1;
                        end
                    end
                    RX_STOP: begin
                        if (w_rx_mid && r_rx_sync[1]) begin
                            r_rx_byte    <= r_rx_shift;
                            r_byte_ready <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_byte_edge = r_byte_ready && !r_byte_ready_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte_ready_d <= 1'b0;
            r_word_idx     <= 1'b0;
            r_lo_byte      <= '0;
            r_word         <= '0;
            r_word_stored  <= 1'b0;
            r_word_ready   <= 1'b0;
        end else begin
            r_byte_ready_d <= r_byte_ready;
            r_word_stored  <= w_byte_edge && r_word_idx;
            if (w_byte_edge) begin
                r_word_ready <= 1'b0;
                r_word_idx   <= !r_word_idx;
                if (!r_word_idx) r_lo_byte <= r_rx_byte;
                else             r_word    <= WORD_WIDTH'({r_rx_byte, r_lo_byte});
            end else if (r_word_stored) begin
                r_word_ready <= 1'b1;
            end
        end
    end

    assign rx_byte    = r_rx_byte;
    assign byte_ready = r_byte_ready;
    assign word       = r_word;
    assign word_ready = r_word_ready;
endmodule

// File: tb/tb_uart_link.sv
// Randomized bench for uart_link: a frame-level reference model checks the TX waveform, RX bytes and assembled words.
module tb_uart_link;
    localparam int CPS = 28;
    localparam int OS  = 16;
    localparam int BIT = CPS * OS;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_n;
    logic [7:0]  tx_data;
    logic        tx;
    logic        ready_to_send;
    logic        lb;
    logic        rx_drv;
    logic        w_rx;
    logic [7:0]  rx_byte;
    logic        byte_ready;
    logic [15:0] word;
    logic        word_ready;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  exp_rx_byte    = 8'h00;
    logic        exp_byte_ready = 1'b0;
    logic [15:0] exp_word       = 16'h0000;
    logic        exp_word_ready = 1'b0;
    logic [7:0]  pair_q[$];

    always #5 clk = ~clk;
    assign w_rx = lb ? tx : rx_drv;

    uart_link #(.CLKS_PER_SAMPLE(CPS), .OVERSAMPLE(OS), .WORD_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start_n(start_n), .tx_data(tx_data),
        .tx(tx), .ready_to_send(ready_to_send), .rx(w_rx),
        .rx_byte(rx_byte), .byte_ready(byte_ready), .word(word), .word_ready(word_ready)
    );

    // Line level of bit k (0..9) of an 8N1 frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic model_good(input logic [7:0] b);
        exp_rx_byte    = b;
        exp_byte_ready = 1'b1;
        pair_q.push_back(b);
        if (pair_q.size() == 2) begin
            exp_word       = {pair_q[1], pair_q[0]};
            exp_word_ready = 1'b1;
            pair_q.delete();
        end else begin
            exp_word_ready = 1'b0;
        end
    endtask

    task automatic model_reset();
        exp_rx_byte    = 8'h00;
        exp_byte_ready = 1'b0;
        exp_word       = 16'h0000;
        exp_word_ready = 1'b0;
        pair_q.delete();
    endtask

    task automatic pulse_start(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        start_n = 1'b0;
        @(negedge clk);
        start_n = 1'b1;
    endtask

    // A bad stop bit is held low for 3/4 of a bit so the receiver cannot mistake it for a new start bit.
    task automatic send_frame(input logic [7:0] b, input bit good_stop);
        for (int k = 0; k < 10; k++) begin
            rx_drv = (k == 9) ? good_stop : frame_bit(b, k);
            repeat ((k == 9 && !good_stop) ? (BIT * 3 / 4) : BIT) @(negedge clk);
        end
        rx_drv = 1'b1;
        if (!good_stop) repeat (BIT) @(negedge clk);
    endtask

    task automatic wait_tx(input logic lvl, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (tx === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_byte_ready(input logic lvl, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (byte_ready === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start_n = 1'b1; tx_data = 8'h00; lb = 1'b0; rx_drv = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else n_pass++;
        n_checks++; if (ready_to_send !== 1'b1) $display("FAIL reset_rts: got %b want 1", ready_to_send); else n_pass++;
        n_checks++; if (rx_byte !== exp_rx_byte) $display("FAIL reset_rx_byte: got %h want %h", rx_byte, exp_rx_byte); else n_pass++;
        n_checks++; if (byte_ready !== exp_byte_ready) $display("FAIL reset_byte_ready: got %b want %b", byte_ready, exp_byte_ready); else n_pass++;
        n_checks++; if (word !== exp_word) $display("FAIL reset_word: got %h want %h", word, exp_word); else n_pass++;
        n_checks++; if (word_ready !== exp_word_ready) $display("FAIL reset_word_ready: got %b want %b", word_ready, exp_word_ready); else n_pass++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback_ab();
        bit ok;
        bit seen_low;
        lb = 1'b1;
        pulse_start(8'hAB);
        n_checks++; if (tx !== 1'b1) $display("FAIL lb_still_idle_tx: got %b want 1", tx); else n_pass++;
        n_checks++; if (ready_to_send !== 1'b1) $display("FAIL lb_still_idle_rts: got %b want 1", ready_to_send); else n_pass++;
        ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ready_to_send === 1'b0) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) $display("FAIL lb_rts_drop: got 1 want 0 within 5 clk"); else n_pass++;
        wait_tx(1'b0, 2 * BIT, ok);
        n_checks++; if (!ok) $display("FAIL lb_start_bit: got no start bit want tx=0 within %0d clk", 2 * BIT); else n_pass++;
        if (ok) begin
            for (int c = 0; c < 10 * BIT; c++) begin
                if (c > 0) @(negedge clk);
                if (c == 500)  tx_data = 8'h00;
                if (c == 1000) start_n = 1'b0;
                if (c == 1001) start_n = 1'b1;
                if ((c % BIT) == 0 || (c % BIT) == BIT - 1) begin
                    n_checks++;
                    if (tx !== frame_bit(8'hAB, c / BIT))
                        $display("FAIL lb_wave bit %0d clk %0d: got %b want %b", c / BIT, c % BIT, tx, frame_bit(8'hAB, c / BIT));
                    else n_pass++;
                end
            end
        end
        model_good(8'hAB);
        n_checks++; if (rx_byte !== exp_rx_byte) $display("FAIL lb_rx_byte: got %h want %h", rx_byte, exp_rx_byte); else n_pass++;
        n_checks++; if (byte_ready !== exp_byte_ready) $display("FAIL lb_byte_ready: got %b want %b", byte_ready, exp_byte_ready); else n_pass++;
        n_checks++; if (word !== exp_word) $display("FAIL lb_word_kept: got %h want %h", word, exp_word); else n_pass++;
        n_checks++; if (word_ready !== exp_word_ready) $display("FAIL lb_word_ready: got %b want %b", word_ready, exp_word_ready); else n_pass++;
        seen_low = 1'b0;
        repeat (2 * BIT) begin
            @(negedge clk);
            if (tx === 1'b0) seen_low = 1'b1;
        end
        n_checks++; if (seen_low) $display("FAIL lb_no_queue: got tx low want idle high"); else n_pass++;
        n_checks++; if (ready_to_send !== 1'b1) $display("FAIL lb_rts_back: got %b want 1", ready_to_send); else n_pass++;
    endtask

    task automatic test_word();
        bit ok;
        pulse_start(8'hCD);
        wait_byte_ready(1'b0, 3 * BIT, ok);
        n_checks++; if (!ok) $display("FAIL word_br_clear: got 1 want 0 after start bit"); else n_pass++;
        wait_byte_ready(1'b1, 11 * BIT, ok);
        n_checks++; if (!ok) $display("FAIL word_br_set: got 0 want 1 after frame"); else n_pass++;
        n_checks++; if (rx_byte !== 8'hCD) $display("FAIL word_rx_byte: got %h want cd", rx_byte); else n_pass++;
        n_checks++; if (word !== exp_word) $display("FAIL word_old_kept: got %h want %h", word, exp_word); else n_pass++;
        n_checks++; if (word_ready !== exp_word_ready) $display("FAIL word_ready_early: got %b want %b", word_ready, exp_word_ready); else n_pass++;
        model_good(8'hCD);
        @(negedge clk);
        n_checks++; if (word !== exp_word) $display("FAIL word_value: got %h want %h", word, exp_word); else n_pass++;
        n_checks++; if (word !== 16'hCDAB) $display("FAIL word_cdab: got %h want cdab", word); else n_pass++;
        n_checks++; if (word_ready !== 1'b0) $display("FAIL word_ready_lag: got %b want 0", word_ready); else n_pass++;
        @(negedge clk);
        n_checks++; if (word_ready !== exp_word_ready) $display("FAIL word_ready_rise: got %b want %b", word_ready, exp_word_ready); else n_pass++;
        repeat (BIT) @(negedge clk);
        lb = 1'b0;
    endtask

    task automatic test_random_rx();
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            repeat ($urandom_range(1, 300)) @(negedge clk);
            send_frame(b, 1'b1);
            model_good(b);
            n_checks++; if (rx_byte !== exp_rx_byte) $display("FAIL rand_rx_byte %0d: got %h want %h", i, rx_byte, exp_rx_byte); else n_pass++;
            n_checks++; if (byte_ready !== exp_byte_ready) $display("FAIL rand_byte_ready %0d: got %b want %b", i, byte_ready, exp_byte_ready); else n_pass++;
            n_checks++; if (word !== exp_word) $display("FAIL rand_word %0d: got %h want %h", i, word, exp_word); else n_pass++;
            n_checks++; if (word_ready !== exp_word_ready) $display("FAIL rand_word_ready %0d: got %b want %b", i, word_ready, exp_word_ready); else n_pass++;
        end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (4 * CPS) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        n_checks++; if (byte_ready !== exp_byte_ready) $display("FAIL glitch_byte_ready: got %b want %b", byte_ready, exp_byte_ready); else n_pass++;
        n_checks++; if (rx_byte !== exp_rx_byte) $display("FAIL glitch_rx_byte: got %h want %h", rx_byte, exp_rx_byte); else n_pass++;
        n_checks++; if (word_ready !== exp_word_ready) $display("FAIL glitch_word_ready: got %b want %b", word_ready, exp_word_ready); else n_pass++;
    endtask

    task automatic test_bad_stop();
        logic [7:0] x, y, z;
        x = 8'($urandom); y = ~x; z = 8'($urandom);
        send_frame(x, 1'b1);
        model_good(x);
        n_checks++; if (rx_byte !== exp_rx_byte) $display("FAIL bad_pre_rx_byte: got %h want %h", rx_byte, exp_rx_byte); else n_pass++;
        send_frame(y, 1'b0);
        // The confirmed start bit clears byte_ready; the bad stop bit then leaves it and rx_byte alone.
        exp_byte_ready = 1'b0;
        n_checks++; if (rx_byte !== exp_rx_byte) $display("FAIL bad_rx_byte: got %h want %h", rx_byte, exp_rx_byte); else n_pass++;
        n_checks++; if (byte_ready !== exp_byte_ready) $display("FAIL bad_byte_ready: got %b want %b", byte_ready, exp_byte_ready); else n_pass++;
        n_checks++; if (word_ready !== exp_word_ready) $display("FAIL bad_word_ready: got %b want %b", word_ready, exp_word_ready); else n_pass++;
        send_frame(z, 1'b1);
        model_good(z);
        n_checks++; if (rx_byte !== exp_rx_byte) $display("FAIL bad_post_rx_byte: got %h want %h", rx_byte, exp_rx_byte); else n_pass++;
        n_checks++; if (word !== exp_word) $display("FAIL bad_post_word: got %h want %h", word, exp_word); else n_pass++;
        n_checks++; if (word_ready !== exp_word_ready) $display("FAIL bad_post_word_ready: got %b want %b", word_ready, exp_word_ready); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit bad_tx;
        bit bad_br;
        lb = 1'b1;
        pulse_start(8'($urandom));
        wait_tx(1'b0, 2 * BIT, ok);
        n_checks++; if (!ok) $display("FAIL rmid_start_bit: got no start bit want tx=0"); else n_pass++;
        repeat (3 * BIT) @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        n_checks++; if (tx !== 1'b1) $display("FAIL rmid_tx: got %b want 1", tx); else n_pass++;
        n_checks++; if (ready_to_send !== 1'b1) $display("FAIL rmid_rts: got %b want 1", ready_to_send); else n_pass++;
        n_checks++; if (rx_byte !== exp_rx_byte) $display("FAIL rmid_rx_byte: got %h want %h", rx_byte, exp_rx_byte); else n_pass++;
        n_checks++; if (byte_ready !== exp_byte_ready) $display("FAIL rmid_byte_ready: got %b want %b", byte_ready, exp_byte_ready); else n_pass++;
        n_checks++; if (word !== exp_word) $display("FAIL rmid_word: got %h want %h", word, exp_word); else n_pass++;
        n_checks++; if (word_ready !== exp_word_ready) $display("FAIL rmid_word_ready: got %b want %b", word_ready, exp_word_ready); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        bad_tx = 1'b0;
        bad_br = 1'b0;
        repeat (11 * BIT) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx = 1'b1;
            if (byte_ready !== 1'b0) bad_br = 1'b1;
        end
        n_checks++; if (bad_tx) $display("FAIL rmid_tx_abort: got activity want idle high"); else n_pass++;
        n_checks++; if (bad_br) $display("FAIL rmid_partial: got byte_ready 1 want 0"); else n_pass++;
        lb = 1'b0;
    endtask

    initial begin
        test_reset();
        test_loopback_ab();
        test_word();
        test_random_rx();
        test_glitch();
        test_bad_stop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule
